// File: rtl/mem_arbiter.sv
//============================================================================
// Module      : mem_arbiter
// Description : Two-master memory arbiter. Instruction reads, data reads and
//               data writes from a stalling CPU front end are captured into
//               pending slots and replayed one at a time onto a single
//               request/grant/response bus. Fixed service order is
//               write -> data read -> instruction read.
//               Optional feature macro: MEM_ARBITER_RR_EN
//                 When defined, the relative order of the two reads
//                 alternates on every batch in which both reads arrive
//                 together. The first such batch is served data-first.
//                 Writes are always served first.
// Ports       :
//   CLK                     clock, rising edge
//   RST                     asynchronous reset, active low
//   INST_RDEN/RIADDR        instruction read request and address
//   INST_ROADDR/RVALID/RDATA instruction read response
//   DATA_RDEN/RIADDR        data read request and address
//   DATA_ROADDR/RVALID/RDATA data read response
//   DATA_WREN/WSTRB/WADDR/WDATA data write request
//   MEM_WAIT                stall to upstream (registered)
//   BUS_REQ/WE/ADDR/WSTRB/WDATA bus request (registered)
//   BUS_GNT                 bus accepts the current request
//   BUS_RVALID/RDATA        bus read response
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module mem_arbiter (
    input  logic        CLK,
    input  logic        RST,
    input  logic        INST_RDEN,
    input  logic [31:0] INST_RIADDR,
    output logic [31:0] INST_ROADDR,
    output logic        INST_RVALID,
    output logic [31:0] INST_RDATA,
    input  logic        DATA_RDEN,
    input  logic [31:0] DATA_RIADDR,
    output logic [31:0] DATA_ROADDR,
    output logic        DATA_RVALID,
    output logic [31:0] DATA_RDATA,
    input  logic        DATA_WREN,
    input  logic [3:0]  DATA_WSTRB,
    input  logic [31:0] DATA_WADDR,
    input  logic [31:0] DATA_WDATA,
    output logic        MEM_WAIT,
    output logic        BUS_REQ,
    output logic        BUS_WE,
    output logic [31:0] BUS_ADDR,
    output logic [3:0]  BUS_WSTRB,
    output logic [31:0] BUS_WDATA,
    input  logic        BUS_GNT,
    input  logic        BUS_RVALID,
    input  logic [31:0] BUS_RDATA
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] SEL_WR = 2'd0;
    localparam logic [1:0] SEL_DR = 2'd1;
    localparam logic [1:0] SEL_IR = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  r_sel;

    // pending slots
    logic        r_wr_pend;
    logic [31:0] r_wr_addr;
    logic [3:0]  r_wr_strb;
    logic [31:0] r_wr_data;
    logic        r_dr_pend;
    logic [31:0] r_dr_addr;
    logic        r_ir_pend;
    logic [31:0] r_ir_addr;

    logic        r_mem_wait;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_wstrb;
    logic [31:0] r_bus_wdata;
    logic        r_inst_rvalid;
    logic [31:0] r_inst_roaddr;
    logic [31:0] r_inst_rdata;
    logic        r_data_rvalid;
    logic [31:0] r_data_roaddr;
    logic [31:0] r_data_rdata;

    logic        w_capture;
    logic        w_wr_c;
    logic        w_dr_c;
    logic        w_ir_c;
    logic [31:0] w_wr_addr_c;
    logic [3:0]  w_wr_strb_c;
    logic [31:0] w_wr_data_c;
    logic [31:0] w_dr_addr_c;
    logic [31:0] w_ir_addr_c;
    logic        w_inst_first;
    logic [1:0]  w_sel;
    logic        w_start;
    logic        w_gnt_ok;
    logic        w_rv_ok;
    logic        w_wr_nxt;
    logic        w_dr_nxt;
    logic        w_ir_nxt;

    // MEM_WAIT low means every slot is empty and the FSM is idle, so a new
    // request set is only ever captured in IDLE.
    assign w_capture = (r_state == S_IDLE) && !r_mem_wait;

    // Candidate slot contents: on a capture edge the incoming request is
    // dispatched straight to the bus so BUS_REQ rises one cycle after the
    // request edge; otherwise the stored slots are used.
    assign w_wr_c      = w_capture ? DATA_WREN   : r_wr_pend;
    assign w_dr_c      = w_capture ? DATA_RDEN   : r_dr_pend;
    assign w_ir_c      = w_capture ? INST_RDEN   : r_ir_pend;
    assign w_wr_addr_c = w_capture ? DATA_WADDR  : r_wr_addr;
    assign w_wr_strb_c = w_capture ? DATA_WSTRB  : r_wr_strb;
    assign w_wr_data_c = w_capture ? DATA_WDATA  : r_wr_data;
    assign w_dr_addr_c = w_capture ? DATA_RIADDR : r_dr_addr;
    assign w_ir_addr_c = w_capture ? INST_RIADDR : r_ir_addr;

`ifdef MEM_ARBITER_RR_EN
    logic r_rr_ptr;            // 1: next dual-read batch goes inst-first
    logic r_batch_inst_first;  // order latched for the batch in flight

    assign w_inst_first = w_capture ? r_rr_ptr : r_batch_inst_first;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rr_ptr           <= 1'b0;
            r_batch_inst_first <= 1'b0;
        end else if (w_capture && DATA_RDEN && INST_RDEN) begin
            r_batch_inst_first <= r_rr_ptr;
            r_rr_ptr           <= ~r_rr_ptr;
        end
    end
`else
    assign w_inst_first = 1'b0;
`endif

    assign w_gnt_ok = (r_state == S_REQ)  && BUS_GNT;
    assign w_rv_ok  = (r_state == S_RESP) && BUS_RVALID;
    assign w_start  = (r_state == S_IDLE) && (w_wr_c || w_dr_c || w_ir_c);

    always_comb begin
        w_sel = SEL_WR;
        if (w_wr_c) begin
            w_sel = SEL_WR;
        end else if (w_dr_c && w_ir_c) begin
            w_sel = w_inst_first ? SEL_IR : SEL_DR;
        end else if (w_dr_c) begin
            w_sel = SEL_DR;
        end else if (w_ir_c) begin
            w_sel = SEL_IR;
        end
    end

    // Next slot occupancy; also feeds the registered MEM_WAIT.
    always_comb begin
        w_wr_nxt = r_wr_pend;
        w_dr_nxt = r_dr_pend;
        w_ir_nxt = r_ir_pend;
        if (w_capture) begin
            w_wr_nxt = DATA_WREN;
            w_dr_nxt = DATA_RDEN;
            w_ir_nxt = INST_RDEN;
        end
        if (w_gnt_ok && (r_sel == SEL_WR)) begin
            w_wr_nxt = 1'b0;
        end
        if (w_rv_ok && (r_sel == SEL_DR)) begin
            w_dr_nxt = 1'b0;
        end
        if (w_rv_ok && (r_sel == SEL_IR)) begin
            w_ir_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state       <= S_IDLE;
            r_sel         <= SEL_WR;
            r_wr_pend     <= 1'b0;
            r_wr_addr     <= 32'd0;
            r_wr_strb     <= 4'd0;
            r_wr_data     <= 32'd0;
            r_dr_pend     <= 1'b0;
            r_dr_addr     <= 32'd0;
            r_ir_pend     <= 1'b0;
            r_ir_addr     <= 32'd0;
            r_mem_wait    <= 1'b0;
            r_bus_req     <= 1'b0;
            r_bus_we      <= 1'b0;
            r_bus_addr    <= 32'd0;
            r_bus_wstrb   <= 4'd0;
            r_bus_wdata   <= 32'd0;
            r_inst_rvalid <= 1'b0;
            r_inst_roaddr <= 32'd0;
            r_inst_rdata  <= 32'd0;
            r_data_rvalid <= 1'b0;
            r_data_roaddr <= 32'd0;
            r_data_rdata  <= 32'd0;
        end else begin
            r_wr_pend  <= w_wr_nxt;
            r_dr_pend  <= w_dr_nxt;
            r_ir_pend  <= w_ir_nxt;
            r_mem_wait <= w_wr_nxt || w_dr_nxt || w_ir_nxt;

            if (w_capture) begin
                r_wr_addr <= DATA_WADDR;
                r_wr_strb <= DATA_WSTRB;
                r_wr_data <= DATA_WDATA;
                r_dr_addr <= DATA_RIADDR;
                r_ir_addr <= INST_RIADDR;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state   <= S_REQ;
                        r_sel     <= w_sel;
                        r_bus_req <= 1'b1;
                        case (w_sel)
                            SEL_WR: begin
                                r_bus_we    <= 1'b1;
                                r_bus_addr  <= w_wr_addr_c;
                                r_bus_wstrb <= w_wr_strb_c;
                                r_bus_wdata <= w_wr_data_c;
                            end
                            SEL_DR: begin
                                r_bus_we    <= 1'b0;
                                r_bus_addr  <= w_dr_addr_c;
                                r_bus_wstrb <= 4'd0;
                                r_bus_wdata <= 32'd0;
                            end
                            default: begin
                                r_bus_we    <= 1'b0;
                                r_bus_addr  <= w_ir_addr_c;
                                r_bus_wstrb <= 4'd0;
                                r_bus_wdata <= 32'd0;
                            end
                        endcase
                    end
                end
                S_REQ: begin
                    if (BUS_GNT) begin
                        r_bus_req <= 1'b0;
                        r_bus_we  <= 1'b0;
                        r_state   <= (r_sel == SEL_WR) ? S_IDLE : S_RESP;
                    end
                end
                S_RESP: begin
                    if (BUS_RVALID) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Single-cycle response pulses; address/data hold otherwise.
            r_inst_rvalid <= w_rv_ok && (r_sel == SEL_IR);
            r_data_rvalid <= w_rv_ok && (r_sel == SEL_DR);
            if (w_rv_ok && (r_sel == SEL_IR)) begin
                r_inst_roaddr <= r_ir_addr;
                r_inst_rdata  <= BUS_RDATA;
            end
            if (w_rv_ok && (r_sel == SEL_DR)) begin
                r_data_roaddr <= r_dr_addr;
                r_data_rdata  <= BUS_RDATA;
            end
        end
    end

    assign MEM_WAIT    = r_mem_wait;
    assign BUS_REQ     = r_bus_req;
    assign BUS_WE      = r_bus_we;
    assign BUS_ADDR    = r_bus_addr;
    assign BUS_WSTRB   = r_bus_wstrb;
    assign BUS_WDATA   = r_bus_wdata;
    assign INST_RVALID = r_inst_rvalid;
    assign INST_ROADDR = r_inst_roaddr;
    assign INST_RDATA  = r_inst_rdata;
    assign DATA_RVALID = r_data_rvalid;
    assign DATA_ROADDR = r_data_roaddr;
    assign DATA_RDATA  = r_data_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboard bench for mem_arbiter. Stimulus pushes expected
//               bus requests and read responses into queues; independent
//               monitors pop and compare whenever the DUT raises BUS_REQ or
//               an RVALID. A behavioural bus slave provides grants and read
//               data with programmable delays.
//               Honours MEM_ARBITER_RR_EN for the read-order expectation.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        CLK;
    logic        RST;
    logic        INST_RDEN;
    logic [31:0] INST_RIADDR;
    logic [31:0] INST_ROADDR;
    logic        INST_RVALID;
    logic [31:0] INST_RDATA;
    logic        DATA_RDEN;
    logic [31:0] DATA_RIADDR;
    logic [31:0] DATA_ROADDR;
    logic        DATA_RVALID;
    logic [31:0] DATA_RDATA;
    logic        DATA_WREN;
    logic [3:0]  DATA_WSTRB;
    logic [31:0] DATA_WADDR;
    logic [31:0] DATA_WDATA;
    logic        MEM_WAIT;
    logic        BUS_REQ;
    logic        BUS_WE;
    logic [31:0] BUS_ADDR;
    logic [3:0]  BUS_WSTRB;
    logic [31:0] BUS_WDATA;
    logic        BUS_GNT;
    logic        BUS_RVALID;
    logic [31:0] BUS_RDATA;

    int n_checks = 0;
    int n_fail   = 0;
    int gnt_dly  = 0;
    int rv_dly   = 0;

    logic [68:0] bus_q[$];    // {we, strb, addr, wdata}
    logic [64:0] resp_q[$];   // {is_inst, addr, data}
    logic [31:0] rdata_q[$];  // slave read data, in bus order

    mem_arbiter dut (
        .CLK(CLK), .RST(RST),
        .INST_RDEN(INST_RDEN), .INST_RIADDR(INST_RIADDR),
        .INST_ROADDR(INST_ROADDR), .INST_RVALID(INST_RVALID), .INST_RDATA(INST_RDATA),
        .DATA_RDEN(DATA_RDEN), .DATA_RIADDR(DATA_RIADDR),
        .DATA_ROADDR(DATA_ROADDR), .DATA_RVALID(DATA_RVALID), .DATA_RDATA(DATA_RDATA),
        .DATA_WREN(DATA_WREN), .DATA_WSTRB(DATA_WSTRB),
        .DATA_WADDR(DATA_WADDR), .DATA_WDATA(DATA_WDATA),
        .MEM_WAIT(MEM_WAIT),
        .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR),
        .BUS_WSTRB(BUS_WSTRB), .BUS_WDATA(BUS_WDATA),
        .BUS_GNT(BUS_GNT), .BUS_RVALID(BUS_RVALID), .BUS_RDATA(BUS_RDATA)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_bus(input logic we, input logic [3:0] strb,
                           input logic [31:0] addr, input logic [31:0] wdata);
        bus_q.push_back({we, strb, addr, wdata});
    endtask

    task automatic exp_resp(input logic is_inst, input logic [31:0] addr, input logic [31:0] data);
        resp_q.push_back({is_inst, addr, data});
    endtask

    task automatic issue(input logic ir, input logic [31:0] ia,
                         input logic dr, input logic [31:0] da,
                         input logic wr, input logic [31:0] wa,
                         input logic [3:0] ws, input logic [31:0] wd);
        chk("ready_before_issue", 72'(MEM_WAIT), 72'd0);
        INST_RDEN = ir; INST_RIADDR = ia;
        DATA_RDEN = dr; DATA_RIADDR = da;
        DATA_WREN = wr; DATA_WADDR = wa; DATA_WSTRB = ws; DATA_WDATA = wd;
        @(negedge CLK);
        INST_RDEN = 1'b0; DATA_RDEN = 1'b0; DATA_WREN = 1'b0;
    endtask

    // Returns at the first negedge where MEM_WAIT is low.
    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        while (MEM_WAIT === 1'b1 && cyc < 200) begin
            @(negedge CLK);
            cyc++;
        end
        if (cyc >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: MEM_WAIT still high after %0d cycles, required low", name, cyc);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_bus_req"},     72'(BUS_REQ),     72'd0);
        chk({name, "_bus_we"},      72'(BUS_WE),      72'd0);
        chk({name, "_bus_addr"},    72'(BUS_ADDR),    72'd0);
        chk({name, "_bus_wstrb"},   72'(BUS_WSTRB),   72'd0);
        chk({name, "_bus_wdata"},   72'(BUS_WDATA),   72'd0);
        chk({name, "_inst_rvalid"}, 72'(INST_RVALID), 72'd0);
        chk({name, "_inst_roaddr"}, 72'(INST_ROADDR), 72'd0);
        chk({name, "_inst_rdata"},  72'(INST_RDATA),  72'd0);
        chk({name, "_data_rvalid"}, 72'(DATA_RVALID), 72'd0);
        chk({name, "_data_roaddr"}, 72'(DATA_ROADDR), 72'd0);
        chk({name, "_data_rdata"},  72'(DATA_RDATA),  72'd0);
        chk({name, "_mem_wait"},    72'(MEM_WAIT),    72'd0);
    endtask

    // Behavioural bus slave
    initial begin : slave
        logic rsp_rd;
        BUS_GNT = 1'b0; BUS_RVALID = 1'b0; BUS_RDATA = 32'd0;
        forever begin
            @(negedge CLK);
            if (BUS_REQ === 1'b1) begin
                repeat (gnt_dly) @(negedge CLK);
                BUS_GNT = 1'b1;
                rsp_rd  = !BUS_WE;
                @(negedge CLK);
                BUS_GNT = 1'b0;
                if (rsp_rd) begin
                    repeat (rv_dly) @(negedge CLK);
                    BUS_RVALID = 1'b1;
                    if (rdata_q.size() > 0) BUS_RDATA = rdata_q.pop_front();
                    else                    BUS_RDATA = 32'd0;
                    @(negedge CLK);
                    BUS_RVALID = 1'b0;
                end
            end
        end
    end

    // Bus request monitor: new request pops the scoreboard, held request
    // must not change.
    logic        prev_req = 1'b0;
    logic [68:0] held_req = '0;
    always @(negedge CLK) begin : mon_bus
        logic [68:0] e;
        if (BUS_REQ === 1'b1 && prev_req !== 1'b1) begin
            if (bus_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_bus_req: got addr %h we %b, required no request", BUS_ADDR, BUS_WE);
            end else begin
                e = bus_q.pop_front();
                chk("bus_req_fields", 72'({BUS_WE, BUS_WSTRB, BUS_ADDR, BUS_WDATA}), 72'(e));
            end
            held_req = {BUS_WE, BUS_WSTRB, BUS_ADDR, BUS_WDATA};
        end else if (BUS_REQ === 1'b1) begin
            chk("bus_req_stable", 72'({BUS_WE, BUS_WSTRB, BUS_ADDR, BUS_WDATA}), 72'(held_req));
        end
        prev_req = BUS_REQ;
    end

    // Read response monitor
    always @(negedge CLK) begin : mon_resp
        logic [64:0] e;
        if (INST_RVALID === 1'b1 || DATA_RVALID === 1'b1) begin
            chk("single_rvalid", 72'(INST_RVALID & DATA_RVALID), 72'd0);
            if (resp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rvalid: got inst=%b data=%b, required none", INST_RVALID, DATA_RVALID);
            end else begin
                e = resp_q.pop_front();
                if (INST_RVALID === 1'b1)
                    chk("resp", 72'({1'b1, INST_ROADDR, INST_RDATA}), 72'(e));
                else
                    chk("resp", 72'({1'b0, DATA_ROADDR, DATA_RDATA}), 72'(e));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        RST = 1'b0;
        INST_RDEN = 1'b0; INST_RIADDR = 32'd0;
        DATA_RDEN = 1'b0; DATA_RIADDR = 32'd0;
        DATA_WREN = 1'b0; DATA_WADDR = 32'd0; DATA_WSTRB = 4'd0; DATA_WDATA = 32'd0;
        repeat (3) @(negedge CLK);
        chk_all_zero("reset");
        RST = 1'b1;
        @(negedge CLK);

        // Single instruction read at minimum latency
        gnt_dly = 0; rv_dly = 0;
        exp_bus(1'b0, 4'd0, 32'h100, 32'd0);
        rdata_q.push_back(32'hDEADBEEF);
        exp_resp(1'b1, 32'h100, 32'hDEADBEEF);
        issue(1'b1, 32'h100, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 32'd0);
        chk("t1_busreq_n1",  72'(BUS_REQ), 72'd1);
        chk("t1_wait_n1",    72'(MEM_WAIT), 72'd1);
        @(negedge CLK);
        chk("t1_busreq_n2",  72'(BUS_REQ), 72'd0);
        chk("t1_rvalid_n2",  72'(INST_RVALID), 72'd0);
        @(negedge CLK);
        chk("t1_rvalid_n3",  72'(INST_RVALID), 72'd1);
        chk("t1_wait_n3",    72'(MEM_WAIT), 72'd0);
        @(negedge CLK);
        chk("t1_rvalid_off", 72'(INST_RVALID), 72'd0);
        chk("t1_roaddr_hold", 72'(INST_ROADDR), 72'h100);
        chk("t1_rdata_hold",  72'(INST_RDATA), 72'hDEADBEEF);

        // Write + data read + inst read in one edge
        gnt_dly = 1; rv_dly = 1;
        exp_bus(1'b1, 4'b0011, 32'h200, 32'h1234);
        exp_bus(1'b0, 4'd0, 32'h200, 32'd0);
        exp_bus(1'b0, 4'd0, 32'h0, 32'd0);
        rdata_q.push_back(32'h11112222);
        rdata_q.push_back(32'h33334444);
        exp_resp(1'b0, 32'h200, 32'h11112222);
        exp_resp(1'b1, 32'h0,   32'h33334444);
        issue(1'b1, 32'h0, 1'b1, 32'h200, 1'b1, 32'h200, 4'b0011, 32'h1234);
        chk("t2_wait_hi", 72'(MEM_WAIT), 72'd1);
        wait_idle("t2");
        chk("t2_inst_last_at_wait_drop", 72'(INST_RVALID), 72'd1);

        // Grant withheld for 5 cycles; issued right as MEM_WAIT drops
        gnt_dly = 5; rv_dly = 0;
        exp_bus(1'b0, 4'd0, 32'h300, 32'd0);
        rdata_q.push_back(32'hCAFEF00D);
        exp_resp(1'b0, 32'h300, 32'hCAFEF00D);
        #1;
        issue(1'b0, 32'd0, 1'b1, 32'h300, 1'b0, 32'd0, 4'd0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("t3_req_held",  72'(BUS_REQ), 72'd1);
            chk("t3_addr_held", 72'(BUS_ADDR), 72'h300);
            chk("t3_no_rvalid", 72'(DATA_RVALID), 72'd0);
            @(negedge CLK);
        end
        wait_idle("t3");

        // Reset while waiting for read data
        gnt_dly = 0; rv_dly = 4;
        exp_bus(1'b0, 4'd0, 32'h400, 32'd0);
        rdata_q.push_back(32'h0BAD0BAD);
        #1;
        issue(1'b1, 32'h400, 1'b0, 32'd0, 1'b0, 32'd0, 4'd0, 32'd0);
        @(negedge CLK);
        chk("t4_in_resp_wait", 72'(MEM_WAIT), 72'd1);
        #2 RST = 1'b0;
        #1 chk_all_zero("t4_rst");
        @(negedge CLK);
        #2 RST = 1'b1;
        repeat (6) @(negedge CLK);
        chk("t4_wait_after", 72'(MEM_WAIT), 72'd0);
        chk("t4_req_after",  72'(BUS_REQ), 72'd0);

        // Two dual-read batches
        gnt_dly = 0; rv_dly = 0;
        exp_bus(1'b0, 4'd0, 32'h500, 32'd0);
        exp_bus(1'b0, 4'd0, 32'h600, 32'd0);
        rdata_q.push_back(32'h55555555);
        rdata_q.push_back(32'h66666666);
        exp_resp(1'b0, 32'h500, 32'h55555555);
        exp_resp(1'b1, 32'h600, 32'h66666666);
        #1;
        issue(1'b1, 32'h600, 1'b1, 32'h500, 1'b0, 32'd0, 4'd0, 32'd0);
        wait_idle("t5a");
`ifdef MEM_ARBITER_RR_EN
        exp_bus(1'b0, 4'd0, 32'h800, 32'd0);
        exp_bus(1'b0, 4'd0, 32'h700, 32'd0);
        rdata_q.push_back(32'h88888888);
        rdata_q.push_back(32'h77777777);
        exp_resp(1'b1, 32'h800, 32'h88888888);
        exp_resp(1'b0, 32'h700, 32'h77777777);
`else
        exp_bus(1'b0, 4'd0, 32'h700, 32'd0);
        exp_bus(1'b0, 4'd0, 32'h800, 32'd0);
        rdata_q.push_back(32'h77777777);
        rdata_q.push_back(32'h88888888);
        exp_resp(1'b0, 32'h700, 32'h77777777);
        exp_resp(1'b1, 32'h800, 32'h88888888);
`endif
        #1;
        issue(1'b1, 32'h800, 1'b1, 32'h700, 1'b0, 32'd0, 4'd0, 32'd0);
        wait_idle("t5b");

        repeat (5) @(negedge CLK);
        chk("bus_q_drained",   72'(bus_q.size()),   72'd0);
        chk("resp_q_drained",  72'(resp_q.size()),  72'd0);
        chk("rdata_q_drained", 72'(rdata_q.size()), 72'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
